vx_cache_mshr_ctl: RTL and testbench

- Parametrised next-generation MSHR for one bank of the pipelined multi-banked cache.
- Tracks pending core misses per cache line as arrival-ordered linked lists and replays a whole list on memory fill.
- Additions over the current MSHR generation: occupancy count and almost-full watermark, a fill handshake, a last-in-chain flag on dequeue, and a flush/drain handshake used before cache invalidation.

---
 rtl/vx_cache_mshr_ctl_pkg.sv | 11 +
 rtl/vx_mshr_occupancy.sv | 58 +++++
 rtl/vx_cache_mshr_ctl.sv | 201 ++++++++++++++++++++
 tb/tb_vx_cache_mshr_ctl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_cache_mshr_ctl_pkg.sv
// rtl/vx_cache_mshr_ctl_pkg.sv - shared types and constants for the bank MSHR controller
package vx_cache_mshr_ctl_pkg;
   localparam int MSHR_SIZE_DEF       = 16;
   localparam int LINE_ADDR_WIDTH_DEF = 26;
   localparam logic RESET_LEVEL       = 1'b0;

   typedef logic [$clog2(MSHR_SIZE_DEF)-1:0] mshr_id_t;
   typedef logic [LINE_ADDR_WIDTH_DEF-1:0]   line_addr_t;

   typedef enum logic [1:0] {IDLE, DRAIN, DONE} flush_state_t;
endpackage

// File: rtl/vx_mshr_occupancy.sv
// rtl/vx_mshr_occupancy.sv - clamped MSHR occupancy counter with almost-full watermark
// VX_CACHE_MSHR_PERF_EN adds a peak-occupancy tracker
module vx_mshr_occupancy
   import vx_cache_mshr_ctl_pkg::*;
#(
   parameter int MSHR_SIZE = 16,
   parameter int ALM_FULL  = 14,
   parameter int CNT_W     = 5
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec_release,
   input  logic             dec_dequeue,
   output logic [CNT_W-1:0] occupancy,
   output logic             almost_full
`ifdef VX_CACHE_MSHR_PERF_EN
   ,
   output logic [CNT_W-1:0] peak
`endif
);
   localparam logic [CNT_W:0]   MAX    = (CNT_W+1)'(MSHR_SIZE);
   localparam logic [CNT_W-1:0] ALM_TH = CNT_W'(ALM_FULL);

   logic [CNT_W:0]   sum, sub, diff;
   logic [CNT_W-1:0] count_n;

   // one increment and two decrements land together; clamp to [0, MSHR_SIZE]
   always_comb begin
      sum  = {1'b0, occupancy} + {{CNT_W{1'b0}}, inc};
      sub  = {{CNT_W{1'b0}}, dec_release} + {{CNT_W{1'b0}}, dec_dequeue};
      diff = sum - sub;
      if (sub > sum)
         count_n = '0;
      else if (diff > MAX)
         count_n = MAX[CNT_W-1:0];
      else
         count_n = diff[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (reset == RESET_LEVEL)
         occupancy <= '0;
      else
         occupancy <= count_n;
   end

   assign almost_full = (occupancy >= ALM_TH);

`ifdef VX_CACHE_MSHR_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (reset == RESET_LEVEL)
         peak <= '0;
      else if (count_n > peak)
         peak <= count_n;
   end
`endif
endmodule

// File: rtl/vx_cache_mshr_ctl.sv
// rtl/vx_cache_mshr_ctl.sv - bank MSHR with per-line replay chains, occupancy and flush drain
// VX_CACHE_MSHR_PERF_EN adds perf_allocs/perf_merges/perf_peak counters
module vx_cache_mshr_ctl
   import vx_cache_mshr_ctl_pkg::*;
#(
   parameter int MSHR_SIZE       = 16,
   parameter int LINE_ADDR_WIDTH = 26,
   parameter int DATA_WIDTH      = 64,
   parameter int ALM_FULL        = MSHR_SIZE - 2,
   parameter int WRITEBACK       = 0,
   parameter int MSHR_ADDR_WIDTH = $clog2(MSHR_SIZE)
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fill_valid,
   input  logic [MSHR_ADDR_WIDTH-1:0] fill_id,
   output logic                       fill_ready,
   output logic [LINE_ADDR_WIDTH-1:0] fill_addr,
   output logic                       dequeue_valid,
   output logic [LINE_ADDR_WIDTH-1:0] dequeue_addr,
   output logic                       dequeue_rw,
   output logic [DATA_WIDTH-1:0]      dequeue_data,
   output logic [MSHR_ADDR_WIDTH-1:0] dequeue_id,
   output logic                       dequeue_last,
   input  logic                       dequeue_ready,
   input  logic                       allocate_valid,
   input  logic [LINE_ADDR_WIDTH-1:0] allocate_addr,
   input  logic                       allocate_rw,
   input  logic [DATA_WIDTH-1:0]      allocate_data,
   output logic                       allocate_ready,
   output logic [MSHR_ADDR_WIDTH-1:0] allocate_id,
   output logic                       allocate_pending,
   output logic [MSHR_ADDR_WIDTH-1:0] allocate_previd,
   input  logic                       finalize_valid,
   input  logic                       finalize_is_release,
   input  logic                       finalize_is_pending,
   input  logic [MSHR_ADDR_WIDTH-1:0] finalize_previd,
   input  logic [MSHR_ADDR_WIDTH-1:0] finalize_id,
   input  logic                       flush_valid,
   output logic                       flush_ready,
   output logic [MSHR_ADDR_WIDTH:0]   occupancy,
   output logic                       almost_full
`ifdef VX_CACHE_MSHR_PERF_EN
   ,
   output logic [31:0]                perf_allocs,
   output logic [31:0]                perf_merges,
   output logic [MSHR_ADDR_WIDTH:0]   perf_peak
`endif
);
   logic [MSHR_SIZE-1:0]       valid_q, valid_n, has_next_q, rw_q;
   logic [MSHR_SIZE-1:0]       link_mask, match, tail;
   logic [MSHR_ADDR_WIDTH-1:0] next_idx_q [MSHR_SIZE];
   logic [LINE_ADDR_WIDTH-1:0] addr_q     [MSHR_SIZE];
   logic [DATA_WIDTH-1:0]      data_q     [MSHR_SIZE];

   logic                       alloc_rdy_q, run_q, deq_valid_q, alloc_block;
   logic [MSHR_ADDR_WIDTH-1:0] alloc_id_q, free_id, prev_id, deq_id_q;
   flush_state_t               state_q, state_n;

   logic alloc_fire, release_fire, link_fire, fill_fire, deq_fire;

   assign alloc_fire   = allocate_valid & allocate_ready;
   assign release_fire = finalize_valid & finalize_is_release;
   assign link_fire    = finalize_valid & finalize_is_pending;
   assign fill_fire    = fill_valid & fill_ready;
   assign deq_fire     = deq_valid_q & dequeue_ready;

   always_comb begin
      valid_n = valid_q;
      if (alloc_fire)   valid_n[alloc_id_q]  = 1'b1;
      if (release_fire) valid_n[finalize_id] = 1'b0;
      if (deq_fire)     valid_n[deq_id_q]    = 1'b0;
   end

   always_comb begin
      free_id = '0;
      for (int i = MSHR_SIZE - 1; i >= 0; i--)
         if (!valid_n[i]) free_id = MSHR_ADDR_WIDTH'(i);
   end

   // tail = matching entry still unlinked once this cycle's finalize link lands
   always_comb begin
      link_mask = has_next_q;
      if (link_fire) link_mask[finalize_previd] = 1'b1;
      for (int i = 0; i < MSHR_SIZE; i++)
         match[i] = valid_q[i] && (addr_q[i] == allocate_addr) && ((WRITEBACK != 0) || !rw_q[i]);
      tail    = match & ~link_mask;
      prev_id = '0;
      for (int i = MSHR_SIZE - 1; i >= 0; i--)
         if (tail[i]) prev_id = MSHR_ADDR_WIDTH'(i);
   end

   always_comb begin
      state_n     = state_q;
      alloc_block = 1'b1;
      flush_ready = 1'b0;
      unique case (state_q)
         IDLE: begin
            alloc_block = 1'b0;
            if (flush_valid) state_n = DRAIN;
         end
         DRAIN: if ((occupancy == '0) && !deq_valid_q) state_n = DONE;
         DONE: begin
            flush_ready = 1'b1;
            if (!flush_valid) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (reset == RESET_LEVEL) begin
         valid_q     <= '0;
         has_next_q  <= '0;
         alloc_rdy_q <= 1'b0;
         alloc_id_q  <= '0;
         run_q       <= 1'b0;
         deq_valid_q <= 1'b0;
         deq_id_q    <= '0;
         state_q     <= IDLE;
      end else begin
         valid_q     <= valid_n;
         alloc_rdy_q <= ~&valid_n;
         alloc_id_q  <= free_id;
         run_q       <= 1'b1;
         state_q     <= state_n;
         if (alloc_fire) has_next_q[alloc_id_q]     <= 1'b0;
         if (link_fire)  has_next_q[finalize_previd] <= 1'b1;
         if (fill_fire) begin
            deq_valid_q <= 1'b1;
            deq_id_q    <= fill_id;
         end else if (deq_fire) begin
            if (has_next_q[deq_id_q])
               deq_id_q <= next_idx_q[deq_id_q];
            else if (link_fire && (finalize_previd == deq_id_q))
               deq_id_q <= finalize_id;
            else
               deq_valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         addr_q[alloc_id_q] <= allocate_addr;
         rw_q[alloc_id_q]   <= allocate_rw;
         data_q[alloc_id_q] <= allocate_data;
      end
      if (link_fire) next_idx_q[finalize_previd] <= finalize_id;
   end

   assign allocate_ready   = alloc_rdy_q & ~alloc_block;
   assign allocate_id      = alloc_id_q;
   assign allocate_pending = |match;
   assign allocate_previd  = prev_id;
   assign fill_ready       = run_q & ~deq_valid_q;
   assign fill_addr        = addr_q[fill_id];
   assign dequeue_valid    = deq_valid_q;
   assign dequeue_id       = deq_id_q;
   assign dequeue_addr     = addr_q[deq_id_q];
   assign dequeue_rw       = rw_q[deq_id_q];
   assign dequeue_data     = data_q[deq_id_q];
   assign dequeue_last     = ~has_next_q[deq_id_q];

   vx_mshr_occupancy #(
      .MSHR_SIZE (MSHR_SIZE),
      .ALM_FULL  (ALM_FULL),
      .CNT_W     (MSHR_ADDR_WIDTH + 1)
   ) u_occupancy (
      .clk         (clk),
      .reset       (reset),
      .inc         (alloc_fire),
      .dec_release (release_fire),
      .dec_dequeue (deq_fire),
      .occupancy   (occupancy),
      .almost_full (almost_full)
`ifdef VX_CACHE_MSHR_PERF_EN
      ,
      .peak        (perf_peak)
`endif
   );

`ifdef VX_CACHE_MSHR_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (reset == RESET_LEVEL) begin
         perf_allocs <= '0;
         perf_merges <= '0;
      end else begin
         if (alloc_fire && (perf_allocs != '1))
            perf_allocs <= perf_allocs + 32'd1;
         if (alloc_fire && allocate_pending && (perf_merges != '1))
            perf_merges <= perf_merges + 32'd1;
      end
   end
`endif

   // the granted slot is free by construction, so freeing it in the same cycle is a caller error
   assert property (@(posedge clk) disable iff (reset == RESET_LEVEL)
      !(alloc_fire && ((release_fire && (finalize_id == alloc_id_q)) ||
                       (deq_fire && (deq_id_q == alloc_id_q)))));
endmodule

// File: tb/tb_vx_cache_mshr_ctl.sv
// tb/tb_vx_cache_mshr_ctl.sv - scoreboard bench for vx_cache_mshr_ctl
module tb_vx_cache_mshr_ctl;
   import vx_cache_mshr_ctl_pkg::*;

   localparam int N  = 16;
   localparam int AW = 26;
   localparam int DW = 64;
   localparam int IW = 4;

   logic          clk, reset;
   logic          fill_valid, fill_ready;
   logic [IW-1:0] fill_id;
   logic [AW-1:0] fill_addr;
   logic          dequeue_valid, dequeue_rw, dequeue_last, dequeue_ready;
   logic [AW-1:0] dequeue_addr;
   logic [DW-1:0] dequeue_data;
   logic [IW-1:0] dequeue_id;
   logic          allocate_valid, allocate_rw, allocate_ready, allocate_pending;
   logic [AW-1:0] allocate_addr;
   logic [DW-1:0] allocate_data;
   logic [IW-1:0] allocate_id, allocate_previd;
   logic          finalize_valid, finalize_is_release, finalize_is_pending;
   logic [IW-1:0] finalize_previd, finalize_id;
   logic          flush_valid, flush_ready;
   logic [IW:0]   occupancy;
   logic          almost_full;
`ifdef VX_CACHE_MSHR_PERF_EN
   logic [31:0]   perf_allocs, perf_merges;
   logic [IW:0]   perf_peak;
`endif

   typedef struct {
      logic [IW-1:0] id;
      logic          last;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } deq_exp_t;

   deq_exp_t sb_q[$];
   int checks   = 0;
   int failures = 0;
   int wait_cnt;

   vx_cache_mshr_ctl #(.MSHR_SIZE(N), .LINE_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .fill_valid(fill_valid), .fill_id(fill_id), .fill_ready(fill_ready), .fill_addr(fill_addr),
      .dequeue_valid(dequeue_valid), .dequeue_addr(dequeue_addr), .dequeue_rw(dequeue_rw),
      .dequeue_data(dequeue_data), .dequeue_id(dequeue_id), .dequeue_last(dequeue_last),
      .dequeue_ready(dequeue_ready),
      .allocate_valid(allocate_valid), .allocate_addr(allocate_addr), .allocate_rw(allocate_rw),
      .allocate_data(allocate_data), .allocate_ready(allocate_ready), .allocate_id(allocate_id),
      .allocate_pending(allocate_pending), .allocate_previd(allocate_previd),
      .finalize_valid(finalize_valid), .finalize_is_release(finalize_is_release),
      .finalize_is_pending(finalize_is_pending), .finalize_previd(finalize_previd),
      .finalize_id(finalize_id),
      .flush_valid(flush_valid), .flush_ready(flush_ready),
      .occupancy(occupancy), .almost_full(almost_full)
`ifdef VX_CACHE_MSHR_PERF_EN
      , .perf_allocs(perf_allocs), .perf_merges(perf_merges), .perf_peak(perf_peak)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // one clock: score any dequeue fire, then advance to the next falling edge
   task automatic tick();
      deq_exp_t e;
      #1;
      if (dequeue_valid && dequeue_ready) begin
         if (sb_q.size() == 0) begin
            check_eq("deq_unexpected", 64'(dequeue_id), 64'hFFFF);
         end else begin
            e = sb_q.pop_front();
            check_eq("deq_id", 64'(dequeue_id), 64'(e.id));
            check_eq("deq_last", 64'(dequeue_last), 64'(e.last));
            check_eq("deq_addr", 64'(dequeue_addr), 64'(e.addr));
            check_eq("deq_data", dequeue_data, e.data);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic alloc(input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] d,
                        input int exp_id, input logic exp_pend, input int exp_prev);
      allocate_valid = 1'b1;
      allocate_addr  = a;
      allocate_rw    = rw;
      allocate_data  = d;
      #1;
      check_eq("alloc_ready", 64'(allocate_ready), 64'd1);
      check_eq("alloc_id", 64'(allocate_id), 64'(exp_id));
      check_eq("alloc_pending", 64'(allocate_pending), 64'(exp_pend));
      if (exp_pend) check_eq("alloc_previd", 64'(allocate_previd), 64'(exp_prev));
      tick();
      allocate_valid = 1'b0;
   endtask

   task automatic fin(input int id, input logic rel, input logic pend, input int prev);
      finalize_valid      = 1'b1;
      finalize_id         = IW'(id);
      finalize_is_release = rel;
      finalize_is_pending = pend;
      finalize_previd     = IW'(prev);
      tick();
      finalize_valid      = 1'b0;
      finalize_is_release = 1'b0;
      finalize_is_pending = 1'b0;
   endtask

   // assumes an empty table: entries land in ids 0..n-1, each linked behind the previous
   task automatic build_chain(input logic [AW-1:0] a, input int n, input logic [DW-1:0] dbase);
      deq_exp_t e;
      for (int k = 0; k < n; k++) begin
         alloc(a, 1'b0, dbase + DW'(k), k, (k > 0), k - 1);
         fin(k, 1'b0, (k > 0), k - 1);
         e.id = IW'(k); e.last = (k == n - 1); e.addr = a; e.data = dbase + DW'(k);
         sb_q.push_back(e);
      end
   endtask

   task automatic run_chain(input logic [AW-1:0] a, input int n);
      fill_valid = 1'b1;
      fill_id    = '0;
      #1;
      check_eq("fill_ready_idle", 64'(fill_ready), 64'd1);
      check_eq("fill_addr", 64'(fill_addr), 64'(a));
      tick();
      fill_valid    = 1'b0;
      dequeue_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         check_eq("deq_valid_chain", 64'(dequeue_valid), 64'd1);
         check_eq("fill_ready_busy", 64'(fill_ready), 64'd0);
         tick();
      end
      dequeue_ready = 1'b0;
      check_eq("deq_valid_end", 64'(dequeue_valid), 64'd0);
   endtask

   initial begin
      deq_exp_t e;
      reset = 1'b0;
      fill_valid = 0; fill_id = '0; dequeue_ready = 0;
      allocate_valid = 0; allocate_addr = '0; allocate_rw = 0; allocate_data = '0;
      finalize_valid = 0; finalize_is_release = 0; finalize_is_pending = 0;
      finalize_previd = '0; finalize_id = '0; flush_valid = 0;
      repeat (2) @(negedge clk);

      check_eq("rst_alloc_ready", 64'(allocate_ready), 64'd0);
      check_eq("rst_deq_valid", 64'(dequeue_valid), 64'd0);
      check_eq("rst_fill_ready", 64'(fill_ready), 64'd0);
      check_eq("rst_flush_ready", 64'(flush_ready), 64'd0);
      check_eq("rst_occupancy", 64'(occupancy), 64'd0);
      check_eq("rst_almost_full", 64'(almost_full), 64'd0);
      reset = 1'b1;
      tick();
      check_eq("post_rst_alloc_ready", 64'(allocate_ready), 64'd1);
      check_eq("post_rst_alloc_id", 64'(allocate_id), 64'd0);

      // fill every slot at distinct lines
      for (int i = 0; i < N; i++) begin
         alloc(AW'(32'h100 + i), 1'b0, DW'(32'h1000 + i), i, 1'b0, 0);
         check_eq("fill_occupancy", 64'(occupancy), 64'(i + 1));
         check_eq("fill_almost_full", 64'(almost_full), 64'((i + 1) >= (N - 2)));
      end
      check_eq("full_alloc_ready", 64'(allocate_ready), 64'd0);
      fin(5, 1'b1, 1'b0, 0);
      check_eq("refree_occupancy", 64'(occupancy), 64'd15);
      check_eq("refree_alloc_ready", 64'(allocate_ready), 64'd1);
      check_eq("refree_alloc_id", 64'(allocate_id), 64'd5);
      for (int i = 0; i < N; i++)
         if (i != 5) fin(i, 1'b1, 1'b0, 0);
      check_eq("empty_occupancy", 64'(occupancy), 64'd0);
      check_eq("empty_almost_full", 64'(almost_full), 64'd0);

      // three merged misses on one line replayed back to back
      build_chain(AW'(32'h2A0), 3, 64'hA000);
      check_eq("chain_occupancy", 64'(occupancy), 64'd3);
      run_chain(AW'(32'h2A0), 3);
      check_eq("chain_drained_occ", 64'(occupancy), 64'd0);

      // link onto the entry being dequeued in the same cycle
      alloc(AW'(32'h3B), 1'b0, 64'hB000, 0, 1'b0, 0);
      fin(0, 1'b0, 1'b0, 0);
      e.id = '0; e.last = 1'b1; e.addr = AW'(32'h3B); e.data = 64'hB000;
      sb_q.push_back(e);
      fill_valid = 1'b1; fill_id = '0;
      tick();
      fill_valid = 1'b0;
      check_eq("late_deq_valid", 64'(dequeue_valid), 64'd1);
      alloc(AW'(32'h3B), 1'b0, 64'hB001, 1, 1'b1, 0);
      e.id = IW'(1); e.last = 1'b1; e.addr = AW'(32'h3B); e.data = 64'hB001;
      sb_q.push_back(e);
      dequeue_ready = 1'b1;
      finalize_valid = 1'b1; finalize_is_pending = 1'b1; finalize_previd = '0; finalize_id = IW'(1);
      tick();
      finalize_valid = 1'b0; finalize_is_pending = 1'b0;
      check_eq("late_no_bubble", 64'(dequeue_valid), 64'd1);
      tick();
      dequeue_ready = 1'b0;
      check_eq("late_deq_done", 64'(dequeue_valid), 64'd0);
      check_eq("late_occupancy", 64'(occupancy), 64'd0);

      // write entries do not merge; released slots are re-granted
      alloc(AW'(32'h4C), 1'b1, 64'hC000, 0, 1'b0, 0);
      fin(0, 1'b0, 1'b0, 0);
      alloc(AW'(32'h4C), 1'b0, 64'hC001, 1, 1'b0, 0);
      fin(1, 1'b1, 1'b0, 0);
      check_eq("rel_alloc_id1", 64'(allocate_id), 64'd1);
      fin(0, 1'b1, 1'b0, 0);
      check_eq("rel_occupancy", 64'(occupancy), 64'd0);
      alloc(AW'(32'h4D), 1'b0, 64'hD000, 0, 1'b0, 0);
      fin(0, 1'b1, 1'b0, 0);
      check_eq("rel_occupancy2", 64'(occupancy), 64'd0);

      // flush drain
      build_chain(AW'(32'h5E), 3, 64'hE000);
      flush_valid = 1'b1;
      tick();
      check_eq("drain_alloc_ready", 64'(allocate_ready), 64'd0);
      check_eq("drain_flush_ready", 64'(flush_ready), 64'd0);
      run_chain(AW'(32'h5E), 3);
      check_eq("drain_occupancy", 64'(occupancy), 64'd0);
      wait_cnt = 0;
      while (!flush_ready && wait_cnt < 2) begin
         tick();
         wait_cnt++;
      end
      check_eq("done_flush_ready", 64'(flush_ready), 64'd1);
      check_eq("done_alloc_ready", 64'(allocate_ready), 64'd0);
      flush_valid = 1'b0;
      tick();
      check_eq("idle_flush_ready", 64'(flush_ready), 64'd0);
      check_eq("idle_alloc_ready", 64'(allocate_ready), 64'd1);

      // reset in the middle of a replay chain
      build_chain(AW'(32'h6F), 2, 64'hF000);
      fill_valid = 1'b1; fill_id = '0;
      tick();
      fill_valid = 1'b0;
      check_eq("midrst_deq_before", 64'(dequeue_valid), 64'd1);
      reset = 1'b0;
      #1;
      check_eq("midrst_deq_valid", 64'(dequeue_valid), 64'd0);
      check_eq("midrst_occupancy", 64'(occupancy), 64'd0);
      check_eq("midrst_alloc_ready", 64'(allocate_ready), 64'd0);
      sb_q.delete();
      @(negedge clk);
      reset = 1'b1;
      tick();
      check_eq("rerst_alloc_ready", 64'(allocate_ready), 64'd1);
      check_eq("rerst_alloc_id", 64'(allocate_id), 64'd0);
      check_eq("rerst_deq_valid", 64'(dequeue_valid), 64'd0);

      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
